pipeline_control_unit: RTL and testbench

- Central hazard and sequencing controller for the 5-stage pipeline: fetch, decode, execute, memory, write-back.
- Generates per-stage stall (hold) and flush (bubble) controls and the fetch PC redirect.
- Covers three hazard classes:
  - load-use data hazards;
  - taken branches resolved in execute;
  - multi-cycle memory accesses using a req/ack handshake.
- Keeps saturating performance counters and a memory-timeout watchdog.
- Sits beside the stage instances in processor_model; drives their enable and flush inputs.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_control_unit_sat_counter.sv | 13 +
 rtl/pipeline_control_unit.sv | 98 +++++++++
 tb/tb_pipeline_control_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM states, stage control bundle and fixed control patterns for the pipeline controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} ctrl_state_t;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
  } stage_ctrl_t;
  localparam stage_ctrl_t CTRL_FREEZE   = 7'b1111001;
  localparam stage_ctrl_t CTRL_BRANCH   = 7'b0000110;
  localparam stage_ctrl_t CTRL_LOAD_USE = 7'b1100010;
  localparam stage_ctrl_t CTRL_REFILL   = 7'b0000100;
endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// sat_counter: W-bit up counter (clk, clear, inc -> count) that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: Mealy hazard controller (hazard inputs -> stage stalls/flushes, pc_redirect, watchdog error, debug state, perf counters)
module pipeline_control_unit import pipeline_ctrl_pkg::*; #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              bubble_wb,
  output logic              pc_redirect,
  output logic              mem_timeout_err,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  ctrl_state_t state, state_nx;
  logic pend, pend_nx;
  logic [WD_W-1:0] wd, wd_nx;
  stage_ctrl_t ctl;
  logic redirect, tmo_err, load_use, mem_stall, timeout;
  assign load_use = ex_mem_read && ex_rd != REG_AW'(REG_ZERO) &&
                    ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  assign mem_stall = mem_req && !mem_ack;
  assign timeout = wd == WD_W'(MEM_TIMEOUT);
  always_comb begin
    ctl = '0;
    redirect = 1'b0;
    tmo_err = 1'b0;
    state_nx = state;
    pend_nx = pend;
    wd_nx = wd;
    if (state == MEM_WAIT) begin
      if (mem_ack) begin
        state_nx = pend ? FLUSH : RUN;
        pend_nx = 1'b0;
        wd_nx = '0;
      end else if (timeout) begin
        tmo_err = 1'b1;
        state_nx = RUN;
        pend_nx = 1'b0;
        wd_nx = '0;
      end else begin
        ctl = CTRL_FREEZE;
        wd_nx = wd + WD_W'(1);
      end
    end else if (mem_stall) begin
      ctl = CTRL_FREEZE;
      state_nx = MEM_WAIT;
      pend_nx = state == FLUSH;
      wd_nx = WD_W'(1);
    end else if (state == FLUSH) begin
      ctl = CTRL_REFILL;
      state_nx = RUN;
    end else if (ex_branch_taken) begin
      ctl = CTRL_BRANCH;
      redirect = 1'b1;
      state_nx = FLUSH;
    end else if (load_use) ctl = CTRL_LOAD_USE;
    if (!rst) begin
      ctl = '0;
      redirect = 1'b0;
      tmo_err = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RUN;
      pend <= 1'b0;
      wd <= '0;
    end else begin
      state <= state_nx;
      pend <= pend_nx;
      wd <= wd_nx;
    end
  assign {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb} = ctl;
  assign pc_redirect = redirect;
  assign mem_timeout_err = tmo_err;
  assign state_o = state;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .clear(!rst), .inc(stall_if), .count(stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .clear(!rst), .inc(redirect), .count(flush_count));
  assert property (@(posedge clk) disable iff (!rst) !(state == FLUSH && ex_branch_taken));
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: directed plus randomized checks of pipeline_control_unit against a behavioural model
module tb_pipeline_control_unit;
  localparam int AW = 5, CW = 4, TMO = 4, CMAX = 15;
  logic clk = 0, rst = 0;
  logic [AW-1:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0, ex_branch_taken = 0, mem_req = 0, mem_ack = 0;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, pc_redirect, mem_timeout_err;
  logic [1:0] state_o;
  logic [CW-1:0] stall_cycles, flush_count;
  int tests = 0, fails = 0;
  int m_state = 0, m_wd = 0, m_stall = 0, m_flush = 0;
  bit m_pend = 0;
  pipeline_control_unit #(.REG_AW(AW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb), .pc_redirect(pc_redirect),
    .mem_timeout_err(mem_timeout_err), .state_o(state_o), .stall_cycles(stall_cycles),
    .flush_count(flush_count));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                        input bit mr, input bit br, input bit req, input bit ack);
    id_rs1 = AW'(rs1);
    id_rs2 = AW'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    ex_rd = AW'(rd);
    ex_mem_read = mr;
    ex_branch_taken = br;
    mem_req = req;
    mem_ack = ack;
  endtask
  task automatic tick();
    bit lu, ms, npend;
    bit [8:0] e;
    int ns, nwd;
    lu = ex_mem_read && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    ms = mem_req && !mem_ack;
    e = '0;
    ns = m_state;
    nwd = m_wd;
    npend = m_pend;
    if (!rst) begin
      ns = 0;
      nwd = 0;
      npend = 0;
    end else if (m_state == 1) begin
      if (mem_ack) begin
        ns = m_pend ? 2 : 0;
        npend = 0;
        nwd = 0;
      end else if (m_wd >= TMO) begin
        e[0] = 1;
        ns = 0;
        npend = 0;
        nwd = 0;
      end else begin
        e = 9'b111100100;
        nwd = m_wd + 1;
      end
    end else if (ms) begin
      e = 9'b111100100;
      ns = 1;
      nwd = 1;
      npend = m_state == 2;
    end else if (m_state == 2) begin
      e[4] = 1;
      ns = 0;
    end else if (ex_branch_taken) begin
      e = 9'b000011010;
      ns = 2;
    end else if (lu) e = 9'b110001000;
    #3;
    check("ctl", 32'({stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb,
                     pc_redirect, mem_timeout_err}), 32'(e));
    @(posedge clk);
    #1;
    m_stall = !rst ? 0 : (m_stall + e[8] > CMAX ? CMAX : m_stall + e[8]);
    m_flush = !rst ? 0 : (m_flush + e[1] > CMAX ? CMAX : m_flush + e[1]);
    m_state = ns;
    m_wd = nwd;
    m_pend = npend;
    check("state", 32'(state_o), 32'(m_state));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("flush_count", 32'(flush_count), 32'(m_flush));
  endtask
  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int ackpct;
    idle(2);
    rst = 1;
    idle(1);
    check("reset_counts", 32'({stall_cycles, flush_count}), 0);
    set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
    tick();
    check("lu_one_stall", 32'(stall_cycles), 1);
    idle(1);
    set_in(0, 0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    check("lu_x0_no_stall", 32'(stall_cycles), 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("br_to_flush", 32'(state_o), 2);
    idle(1);
    check("br_back_run", 32'(state_o), 0);
    check("br_count", 32'(flush_count), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check("mem_wait_stalls", 32'(stall_cycles), 4);
    idle(1);
    set_in(5, 0, 1, 0, 5, 1, 1, 1, 0);
    tick();
    check("prio_mem_wait", 32'(state_o), 1);
    check("prio_no_redirect", 32'(flush_count), 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    tick();
    idle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    #3;
    check("timeout_pulse", 32'(mem_timeout_err), 1);
    tick();
    check("timeout_to_run", 32'(state_o), 0);
    idle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #3;
    check("ack_beats_timeout", 32'(mem_timeout_err), 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check("deferred_flush", 32'(state_o), 2);
    idle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    rst = 0;
    tick();
    check("rst_mid_wait", 32'({state_o, stall_cycles, flush_count}), 0);
    rst = 1;
    idle(1);
    set_in(0, 3, 0, 1, 3, 1, 0, 0, 0);
    repeat (20) tick();
    check("stall_saturates", 32'(stall_cycles), CMAX);
    ackpct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ackpct = 10 + 40 * $urandom_range(2);
      rst = $urandom_range(99) != 0;
      set_in($urandom_range(3), $urandom_range(3), $urandom_range(1), $urandom_range(1),
             $urandom_range(3), $urandom_range(1), m_state != 2 && $urandom_range(3) == 0,
             $urandom_range(2) == 0, $urandom_range(99) < ackpct);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
